// File: rtl/serial_adder_if.sv
// serial_adder_if: operand handshake and result bus for the bit-serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder through one full-adder slice with a registered carry
module serial_adder #(parameter int WIDTH = 8) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, s_i, c_nxt;
  always_comb begin
    s_i   = a_sr[0] ^ b_sr[0] ^ carry;
    c_nxt = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    s_nxt = WIDTH'({s_i, s_sr} >> 1);
  end
  assign bus.busy = state == SHIFT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= s_nxt;
          carry <= c_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // results only move here, so the shifting never shows on sum/cout
            bus.sum  <= s_nxt;
            bus.cout <= c_nxt;
            bus.done <= 1'b1;
            cnt      <= '0;
            state    <= DONE;
          end
        end
        default: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder at WIDTH=8
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  serial_adder_if #(.WIDTH(8)) bus();
  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.a = 8'h5A;
    bus.b = 8'h3C;
    bus.cin = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++;
    if (bus.sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", bus.sum); end
    n_checks++;
    if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", bus.cout); end
    bus.start = 1'b0;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_launch busy got %b want 0", bus.busy); end
  endtask

  task automatic test_add();
    bus.a = 8'h5A;
    bus.b = 8'h3C;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL add_busy cycle %0d busy=%b done=%b want busy=1 done=0", i, bus.busy, bus.done);
      end
      n_checks++;
      if (bus.sum !== 8'h00) begin n_fail++; $display("FAIL add_sum_hidden cycle %0d got %h want 00", i, bus.sum); end
      step();
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
    end
    n_checks++;
    if (bus.sum !== 8'h96 || bus.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result got %b_%h want 0_96", bus.cout, bus.sum);
    end
    step();
    n_checks++;
    if (bus.done !== 1'b0 || bus.sum !== 8'h96) begin
      n_fail++;
      $display("FAIL add_hold done=%b sum=%h want done=0 sum=96", bus.done, bus.sum);
    end
    step();
  endtask

  task automatic test_boundary();
    logic [7:0] av [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] bv [3] = '{8'h01, 8'hFF, 8'h00};
    logic       cv [3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] ev [3] = '{9'h100, 9'h1FF, 9'h001};
    for (int k = 0; k < 3; k++) begin
      bus.a = av[k];
      bus.b = bv[k];
      bus.cin = cv[k];
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) step();
      n_checks++;
      if (bus.done !== 1'b1 || {bus.cout, bus.sum} !== ev[k]) begin
        n_fail++;
        $display("FAIL boundary_%0d done=%b got %b_%h want 1 %h", k, bus.done, bus.cout, bus.sum, ev[k]);
      end
      step();
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    bus.a = 8'h10;
    bus.b = 8'h20;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) begin
        bus.start = 1'b1;
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.cin = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      step();
      if (bus.done === 1'b1) pulses++;
      if (i == 8) begin
        n_checks++;
        if (bus.done !== 1'b1 || bus.sum !== 8'h30 || bus.cout !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_result done=%b got %b_%h want 1 0_30", bus.done, bus.cout, bus.sum);
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle busy=%b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av [3] = '{8'h12, 8'h80, 8'h77};
    logic [7:0] bv [3] = '{8'h34, 8'h80, 8'h11};
    logic       cv [3] = '{1'b0, 1'b1, 1'b0};
    logic [8:0] ev [2] = '{9'h046, 9'h101};
    bus.a = av[0];
    bus.b = bv[0];
    bus.cin = cv[0];
    bus.start = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      bus.a = av[k+1];
      bus.b = bv[k+1];
      bus.cin = cv[k+1];
      for (int j = 1; j <= 8; j++) begin
        step();
        n_checks++;
        if (bus.done !== (j == 8)) begin
          n_fail++;
          $display("FAIL b2b_pulse op %0d cycle %0d done=%b want %b", k, j, bus.done, j == 8);
        end
      end
      n_checks++;
      if ({bus.cout, bus.sum} !== ev[k]) begin
        n_fail++;
        $display("FAIL b2b_result op %0d got %b_%h want %h", k, bus.cout, bus.sum, ev[k]);
      end
      step();
    end
    step();
    step();
    step();
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_third_busy got %b want 1", bus.busy); end
    rst_n = 1'b0;
    bus.start = 1'b0;
    step();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset busy=%b done=%b got %b_%h want 0 0 0_00", bus.busy, bus.done, bus.cout, bus.sum);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (bus.done !== 1'b0 || bus.sum !== 8'h00) begin
        n_fail++;
        $display("FAIL midreset_after cycle %0d done=%b sum=%h want 0 00", i, bus.done, bus.sum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_boundary();
    test_ignore_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
